// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency memory between IF and MEM stages; data has priority, fetch has a starvation guard
// Define ARB_PERF_CNT_EN to add the grant and conflict counters.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              d_req,
    input  logic              d_wen,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              mem_cs,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              if_stall,
    output logic              mem_stall,
`ifdef ARB_PERF_CNT_EN
    output logic [31:0]       if_grant_cnt,
    output logic [31:0]       d_grant_cnt,
    output logic [31:0]       conflict_cnt,
`endif
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    localparam int CW = $clog2(MEM_LAT + 1);
    localparam int SW = $clog2(STARVE_MAX + 1);
    state_t        state;
    logic [CW-1:0] cnt;
    logic [SW-1:0] starve_cnt;
    logic          gnt_d;
    logic          arb, ir, dr, grant_if, grant_d;
    // the port acked this cycle is masked so its still-held request is not re-issued
    assign arb       = state == IDLE || state == RESP;
    assign ir        = if_req & ~if_ack;
    assign dr        = d_req & ~d_ack;
    assign grant_if  = arb & ir & (starve_cnt == SW'(STARVE_MAX) | ~dr);
    assign grant_d   = arb & dr & ~grant_if;
    assign if_stall  = if_req & ~if_ack;
    assign mem_stall = d_req & ~d_ack;
    assign busy      = state != IDLE;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            starve_cnt <= '0;
            gnt_d      <= 1'b0;
            mem_cs     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_rdata   <= '0;
            d_rdata    <= '0;
            if_ack     <= 1'b0;
            d_ack      <= 1'b0;
        end else begin
            mem_cs <= 1'b0;
            if_ack <= 1'b0;
            d_ack  <= 1'b0;
            if (grant_if || !if_req) starve_cnt <= '0;
            else if (grant_d && ir && starve_cnt != SW'(STARVE_MAX)) starve_cnt <= starve_cnt + 1'b1;
            case (state)
                ISSUE: begin
                    state <= mem_we ? RESP : WAIT;
                    cnt   <= CW'(MEM_LAT - 1);
                    if (mem_we) begin
                        if_ack <= ~gnt_d;
                        d_ack  <= gnt_d;
                    end
                end
                WAIT: begin
                    // last WAIT cycle is ISSUE+MEM_LAT: memory data is valid now
                    if (cnt == '0) begin
                        state  <= RESP;
                        if_ack <= ~gnt_d;
                        d_ack  <= gnt_d;
                        if (gnt_d) d_rdata <= mem_rdata;
                        else if_rdata <= mem_rdata;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: ;
            endcase
            if (grant_if || grant_d) begin
                state    <= ISSUE;
                mem_cs   <= 1'b1;
                gnt_d    <= grant_d;
                mem_addr <= grant_d ? d_addr : if_addr;
                mem_we   <= grant_d & d_wen;
                if (grant_d) mem_wdata <= d_wdata;
            end else if (arb) begin
                state <= IDLE;
            end
        end
    end
`ifdef ARB_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_grant_cnt <= '0;
            d_grant_cnt  <= '0;
            conflict_cnt <= '0;
        end else begin
            if (grant_if) if_grant_cnt <= if_grant_cnt + 1'b1;
            if (grant_d) d_grant_cnt <= d_grant_cnt + 1'b1;
            if (arb && ir && dr) conflict_cnt <= conflict_cnt + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: random two-port traffic against a transaction-level model with a scoreboard monitor
module tb_mem_port_arbiter;
    localparam int AW = 32, DW = 32, LAT = 2, SMAX = 4;
    typedef struct { int cyc; bit pd; bit rd; logic [DW-1:0] data; } ack_t;
    typedef struct { int cyc; logic [AW-1:0] addr; bit we; logic [DW-1:0] wdata; } iss_t;
    logic clk = 0, rst_n = 0;
    logic if_req = 0, d_req = 0, d_wen = 0;
    logic [AW-1:0] if_addr = '0, d_addr = '0;
    logic [DW-1:0] d_wdata = '0, mem_rdata = '0;
    logic [DW-1:0] if_rdata, d_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic if_ack, d_ack, mem_cs, mem_we, if_stall, mem_stall, busy;
`ifdef ARB_PERF_CNT_EN
    logic [31:0] if_grant_cnt, d_grant_cnt, conflict_cnt;
`endif
    int cyc = 0, checks = 0, errs = 0;
    ack_t aq[$];
    iss_t iq[$];
    logic [DW-1:0] ref_mem[logic [AW-1:0]];
    logic [DW-1:0] phys_mem[logic [AW-1:0]];
    bit m_busy, m_pd, if_act, d_act, en, want_load;
    int m_ack, starve, b_lo = 0, b_hi = -1, rd_due = -1;
    int m_ifg, m_dg, m_conf;
    logic [AW-1:0] rd_addr = '0;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .if_stall(if_stall), .mem_stall(mem_stall),
`ifdef ARB_PERF_CNT_EN
        .if_grant_cnt(if_grant_cnt), .d_grant_cnt(d_grant_cnt), .conflict_cnt(conflict_cnt),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] mdef(logic [AW-1:0] a);
        return a * 32'h9E3779B1 ^ 32'hDEADBEEF;
    endfunction
    function automatic logic [DW-1:0] rd_ref(logic [AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : mdef(a);
    endfunction
    function automatic logic [DW-1:0] rd_phys(logic [AW-1:0] a);
        return phys_mem.exists(a) ? phys_mem[a] : mdef(a);
    endfunction

    // one transaction at a time; arbitration when idle or on the ack cycle, acked port excluded
    task automatic model(int k);
        bit ack_if, ack_d, ir, dr, gi, gd;
        ack_t a;
        iss_t s;
        ack_if = m_busy && m_ack == k && !m_pd;
        ack_d  = m_busy && m_ack == k && m_pd;
        if (ack_if) if_act = 0;
        if (ack_d) d_act = 0;
        if (ack_if || ack_d) m_busy = 0;
        ir = if_req && !ack_if;
        dr = d_req && !ack_d;
        gi = 0;
        gd = 0;
        if (!m_busy) begin
            gi = ir && (starve == SMAX || !dr);
            gd = dr && !gi;
            if (ir && dr) m_conf++;
        end
        if (gi || gd) begin
            s.cyc = k + 1;
            s.addr = gd ? d_addr : if_addr;
            s.we = gd && d_wen;
            s.wdata = d_wdata;
            a.cyc = k + (s.we ? 2 : 2 + LAT);
            a.pd = gd;
            a.rd = !s.we;
            a.data = rd_ref(s.addr);
            if (s.we) ref_mem[s.addr] = d_wdata;
            iq.push_back(s);
            aq.push_back(a);
            m_busy = 1;
            m_pd = gd;
            m_ack = a.cyc;
            b_lo = k + 1;
            b_hi = a.cyc;
            if (gi) m_ifg++;
            else m_dg++;
        end
        if (gi || !if_req) starve = 0;
        else if (gd && ir && starve < SMAX) starve++;
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) model(cyc);
        #2;
        if (want_load && !d_act) begin
            d_act = 1; d_wen = 0; d_addr = 32'h40; want_load = 0;
        end
        if (!if_act && en && $urandom_range(0, 2) == 0) begin
            if_act = 1;
            if_addr = AW'($urandom_range(0, 15) * 4);
        end
        if (!d_act && en && $urandom_range(0, 2) == 0) begin
            d_act = 1;
            d_wen = 1'($urandom_range(0, 1));
            d_addr = AW'($urandom_range(0, 15) * 4);
            d_wdata = $urandom;
        end
        if_req = if_act;
        d_req = d_act;
    endtask

    task automatic rst_checks(string tag);
        chk({tag, "_mem_cs"}, mem_cs, 0);
        chk({tag, "_mem_we"}, mem_we, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_if_ack"}, if_ack, 0);
        chk({tag, "_d_ack"}, d_ack, 0);
        chk({tag, "_if_rdata"}, if_rdata, 0);
        chk({tag, "_d_rdata"}, d_rdata, 0);
        chk({tag, "_busy"}, busy, 0);
`ifdef ARB_PERF_CNT_EN
        chk({tag, "_if_grant_cnt"}, if_grant_cnt, 0);
        chk({tag, "_d_grant_cnt"}, d_grant_cnt, 0);
        chk({tag, "_conflict_cnt"}, conflict_cnt, 0);
`endif
    endtask

    initial begin : mon
        iss_t s;
        ack_t a;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("if_stall", if_stall, if_req && !if_ack);
                chk("mem_stall", mem_stall, d_req && !d_ack);
                chk("busy", busy, cyc >= b_lo && cyc <= b_hi);
                if (mem_cs || (iq.size() > 0 && iq[0].cyc == cyc)) begin
                    if (iq.size() == 0) chk("issue_unexpected", mem_cs, 0);
                    else begin
                        s = iq.pop_front();
                        chk("issue_cs", mem_cs, 1);
                        chk("issue_cycle", cyc, s.cyc);
                        chk("issue_addr", mem_addr, s.addr);
                        chk("issue_we", mem_we, s.we);
                        if (s.we) chk("issue_wdata", mem_wdata, s.wdata);
                    end
                end
                if (mem_cs) begin
                    if (mem_we) phys_mem[mem_addr] = mem_wdata;
                    else begin
                        rd_due = cyc + LAT;
                        rd_addr = mem_addr;
                    end
                end
                mem_rdata = (cyc == rd_due) ? rd_phys(rd_addr) : $urandom;
                if (if_ack || d_ack || (aq.size() > 0 && aq[0].cyc == cyc)) begin
                    if (aq.size() == 0) chk("ack_unexpected", {if_ack, d_ack}, 0);
                    else begin
                        a = aq.pop_front();
                        chk("ack_cycle", cyc, a.cyc);
                        chk("ack_d", d_ack, a.pd);
                        chk("ack_if", if_ack, !a.pd);
                        if (a.rd) chk(a.pd ? "d_rdata" : "if_rdata", a.pd ? d_rdata : if_rdata, a.data);
                    end
                end
            end
        end
    end

    initial begin
        en = 0;
        repeat (2) @(negedge clk);
        rst_checks("init");
        rst_n = 1;
        en = 1;
        repeat (800) step();
        en = 0;
        for (int i = 0; i < 40 && (m_busy || if_act || d_act); i++) step();
        chk("quiesce", m_busy || if_act || d_act, 0);
        repeat (2) step();
        want_load = 1;
        step();
        step();
        step();
        rst_n = 0;
        #1;
        rst_checks("async_rst");
        aq.delete();
        iq.delete();
        m_busy = 0; if_act = 0; d_act = 0; starve = 0;
        m_ifg = 0; m_dg = 0; m_conf = 0;
        b_lo = 0; b_hi = -1; rd_due = -1;
        if_req = 0; d_req = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        repeat (5) step();
        en = 1;
        repeat (800) step();
        en = 0;
        for (int i = 0; i < 40 && (m_busy || if_act || d_act); i++) step();
        chk("drain", m_busy || if_act || d_act, 0);
        repeat (3) step();
        chk("ack_queue_empty", aq.size(), 0);
        chk("issue_queue_empty", iq.size(), 0);
`ifdef ARB_PERF_CNT_EN
        chk("if_grant_cnt", if_grant_cnt, m_ifg);
        chk("d_grant_cnt", d_grant_cnt, m_dg);
        chk("conflict_cnt", conflict_cnt, m_conf);
`endif
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
